// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: fetch and load/store
// share the port; data wins ties, but a streak limit guarantees fetch progress.
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t      state, state_nxt;
  owner_t      owner, owner_nxt;
  logic        gnt_write, gnt_write_nxt;
  logic [3:0]  streak, streak_nxt;

  logic        decide, any_req, grant_data;

  logic              f_ack_nxt, d_ack_nxt, f_valid_nxt, d_valid_nxt;
  logic              mem_re_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, f_rdata_nxt, d_rdata_nxt;

  // Requests are only looked at on edges leaving IDLE or RESP; ACCESS never samples.
  assign decide     = (state == IDLE) || (state == RESP);
  assign any_req    = f_req || d_req;
  assign grant_data = d_req && (!f_req || (streak != STREAK_MAX));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    gnt_write_nxt = gnt_write;
    streak_nxt    = streak;
    unique case (state)
      IDLE, RESP: state_nxt = any_req ? ACCESS : IDLE;
      ACCESS:     state_nxt = gnt_write ? IDLE : RESP;
      default:    state_nxt = IDLE;
    endcase
    if (decide) begin
      if (grant_data && f_req)
        streak_nxt = (streak == STREAK_MAX) ? streak : streak + 4'd1;
      else
        streak_nxt = 4'd0;
      if (any_req) begin
        owner_nxt     = grant_data ? OWN_DATA : OWN_FETCH;
        gnt_write_nxt = grant_data && d_we;
      end
    end
  end

  always_comb begin
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_re_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    f_ack_nxt     = 1'b0;
    d_ack_nxt     = 1'b0;
    f_valid_nxt   = 1'b0;
    d_valid_nxt   = 1'b0;
    f_rdata_nxt   = f_rdata;
    d_rdata_nxt   = d_rdata;
    // Read data arrives during RESP; only the owner's result register is touched.
    if (state == RESP) begin
      if (owner == OWN_DATA) begin
        d_rdata_nxt = mem_rdata;
        d_valid_nxt = 1'b1;
      end else begin
        f_rdata_nxt = mem_rdata;
        f_valid_nxt = 1'b1;
      end
    end
    if (decide && any_req) begin
      if (grant_data) begin
        mem_addr_nxt = d_addr;
        d_ack_nxt    = 1'b1;
        if (d_we) begin
          mem_we_nxt    = 1'b1;
          mem_wdata_nxt = d_wdata;
        end else begin
          mem_re_nxt = 1'b1;
        end
      end else begin
        mem_addr_nxt = f_addr;
        f_ack_nxt    = 1'b1;
        mem_re_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_FETCH;
      gnt_write <= 1'b0;
      streak    <= 4'd0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      f_valid   <= 1'b0;
      d_valid   <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      owner     <= owner_nxt;
      gnt_write <= gnt_write_nxt;
      streak    <= streak_nxt;
      f_ack     <= f_ack_nxt;
      d_ack     <= d_ack_nxt;
      f_valid   <= f_valid_nxt;
      d_valid   <= d_valid_nxt;
      f_rdata   <= f_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_re    <= mem_re_nxt;
      mem_we    <= mem_we_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected acks/valids,
// a negedge monitor pops and compares whenever the arbiter presents one.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       f_req, d_req, d_we;
  logic [7:0] f_addr, d_addr, d_wdata;
  logic       f_ack, f_valid, d_ack, d_valid, mem_re, mem_we;
  logic [7:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_valid(f_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Synchronous single-port memory: read data appears the cycle after mem_re.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  typedef struct {
    logic       is_data;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } ack_t;

  typedef struct {
    logic       is_data;
    logic [7:0] data;
    int         cyc;
  } val_t;

  ack_t ack_q[$];
  val_t val_q[$];
  ack_t a_e;
  val_t v_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [7:0] exp_f = 8'h00;
  logic [7:0] exp_d = 8'h00;

  // Contention table: grant order D,D,D,D,F,D,D,D,D,F,D with hand-picked data.
  logic       s3_isd  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] s3_addr [11] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h10, 8'h34, 8'h35, 8'h36, 8'h37, 8'h11, 8'h38};
  logic [7:0] s3_data [11] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hA5, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'h96, 8'hC8};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void exp_ack(input logic is_data, input logic we, input logic [7:0] addr,
                                  input logic [7:0] wdata, input int c);
    ack_t e;
    e.is_data = is_data; e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = c;
    ack_q.push_back(e);
  endfunction

  function automatic void exp_val(input logic is_data, input logic [7:0] data, input int c);
    val_t e;
    e.is_data = is_data; e.data = data; e.cyc = c;
    val_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_f = 8'h00;
      exp_d = 8'h00;
    end else begin
      check("strobe_excl", 32'(mem_re & mem_we), 32'd0);
      if (f_ack || d_ack) begin
        if (ack_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_ack: got f_ack=%0b d_ack=%0b, want none (cycle %0d)", f_ack, d_ack, cyc);
        end else begin
          a_e = ack_q.pop_front();
          check("ack_who", 32'(d_ack), 32'(a_e.is_data));
          check("ack_single", 32'(f_ack & d_ack), 32'd0);
          check("ack_cycle", cyc, a_e.cyc);
          check("ack_addr", 32'(mem_addr), 32'(a_e.addr));
          check("ack_we", 32'(mem_we), 32'(a_e.we));
          check("ack_re", 32'(mem_re), 32'(!a_e.we));
          if (a_e.we) check("ack_wdata", 32'(mem_wdata), 32'(a_e.wdata));
        end
      end else begin
        check("strobe_no_ack", 32'({mem_re, mem_we}), 32'd0);
      end
      if (f_valid || d_valid) begin
        if (val_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_valid: got f_valid=%0b d_valid=%0b, want none (cycle %0d)", f_valid, d_valid, cyc);
        end else begin
          v_e = val_q.pop_front();
          check("valid_who", 32'(d_valid), 32'(v_e.is_data));
          check("valid_single", 32'(f_valid & d_valid), 32'd0);
          check("valid_cycle", cyc, v_e.cyc);
          if (v_e.is_data) exp_d = v_e.data;
          else             exp_f = v_e.data;
        end
      end
      check("f_rdata", 32'(f_rdata), 32'(exp_f));
      check("d_rdata", 32'(d_rdata), 32'(exp_d));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch_req(input logic [7:0] addr);
    bit got = 1'b0;
    f_req  = 1'b1;
    f_addr = addr;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = f_ack;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL fetch_ack_timeout: got no f_ack, want f_ack for addr 0x%0h", addr);
    end
    @(posedge clk); #1;
    f_req = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bit got = 1'b0;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = d_ack;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL data_ack_timeout: got no d_ack, want d_ack for addr 0x%0h", addr);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got no completion, want bench end before 20000 time units");
    $fatal(1);
  end

  initial begin
    int s;
    f_req = 1'b0; f_addr = 8'h00;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h96;
    for (int i = 0; i < 9; i++) mem[8'h30 + 8'(i)] = 8'hC0 + 8'(i);

    // Reset state
    tick(2);
    check("reset_flags", 32'({f_ack, f_valid, d_ack, d_valid, mem_re, mem_we}), 32'd0);
    check("reset_buses", {f_rdata, d_rdata, mem_addr, mem_wdata}, 32'd0);
    check("reset_streak", 32'(dut.streak), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Fetch read: ack one cycle after the request is seen, valid two later
    s = cyc;
    exp_ack(1'b0, 1'b0, 8'h10, 8'h00, s + 1);
    exp_val(1'b0, 8'hA5, s + 3);
    fetch_req(8'h10);
    tick(3);
    check("mem_addr_hold", 32'(mem_addr), 32'h10);

    // Data write then read back
    s = cyc;
    exp_ack(1'b1, 1'b1, 8'h20, 8'h3C, s + 1);
    exp_ack(1'b1, 1'b0, 8'h20, 8'h00, s + 3);
    exp_val(1'b1, 8'h3C, s + 5);
    data_req(1'b1, 8'h20, 8'h3C);
    data_req(1'b0, 8'h20, 8'h00);
    tick(4);
    check("mem_wdata_hold", 32'(mem_wdata), 32'h3C);

    // Both requesters saturate the port; streak limit lets fetch in every fifth grant
    s = cyc;
    for (int k = 0; k < 11; k++) begin
      exp_ack(s3_isd[k], 1'b0, s3_addr[k], 8'h00, s + 1 + 2 * k);
      exp_val(s3_isd[k], s3_data[k], s + 3 + 2 * k);
    end
    fork
      begin
        fetch_req(8'h10);
        fetch_req(8'h11);
      end
      begin
        for (int i = 0; i < 9; i++) data_req(1'b0, 8'h30 + 8'(i), 8'h00);
      end
    join
    tick(4);

    // Simultaneous single requests: data first, fetch ack coincides with d_valid
    s = cyc;
    exp_ack(1'b1, 1'b0, 8'h20, 8'h00, s + 1);
    exp_val(1'b1, 8'h3C, s + 3);
    exp_ack(1'b0, 1'b0, 8'h10, 8'h00, s + 3);
    exp_val(1'b0, 8'hA5, s + 5);
    fork
      data_req(1'b0, 8'h20, 8'h00);
      fetch_req(8'h10);
    join
    tick(4);

    // Reset during RESP: no valid for the aborted read, held request re-arbitrated
    s = cyc;
    exp_ack(1'b0, 1'b0, 8'h11, 8'h00, s + 1);
    f_req  = 1'b1;
    f_addr = 8'h11;
    tick(2);
    rst_n = 1'b0;
    #1;
    check("midreset_flags", 32'({f_ack, f_valid, d_ack, d_valid, mem_re, mem_we}), 32'd0);
    check("midreset_buses", {f_rdata, d_rdata, mem_addr, mem_wdata}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    exp_ack(1'b0, 1'b0, 8'h11, 8'h00, s + 5);
    exp_val(1'b0, 8'h96, s + 7);
    fetch_req(8'h11);
    tick(3);

    // Idle: nothing moves for ten cycles
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle_flags", 32'({f_ack, f_valid, d_ack, d_valid, mem_re, mem_we}), 32'd0);
    end
    check("idle_streak", 32'(dut.streak), 32'd0);

    check("ack_q_drained", ack_q.size(), 32'd0);
    check("val_q_drained", val_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
